// File: rtl/add_pkg.sv
// Shared types and constants for the streaming accumulator: FSM states,
// beat-counter width and the clamp limits used by the saturating adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam int COUNT_W = 16;

    // Limits come back as a bit pattern in the low `width` bits; callers truncate.
    function automatic logic [63:0] max_val(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed)
            return (one << (width - 1)) - one;
        if (width >= 64)
            return '1;
        return (one << width) - one;
    endfunction

    function automatic logic [63:0] min_val(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed)
            return one << (width - 1);
        return '0;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational ACCWIDTH-bit adder with overflow detection and optional
// clamping to the representable range of the chosen signedness.
module sat_add
    import add_pkg::*;
#(
    parameter int ACCWIDTH = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic [ACCWIDTH-1:0] a,
    input  logic [ACCWIDTH-1:0] b,
    output logic [ACCWIDTH-1:0] sum,
    output logic                ovf
);

    localparam logic [ACCWIDTH-1:0] MAX_V = ACCWIDTH'(max_val(ACCWIDTH, SIGNED != 0));
    localparam logic [ACCWIDTH-1:0] MIN_V = ACCWIDTH'(min_val(ACCWIDTH, SIGNED != 0));
    localparam int MSB = ACCWIDTH - 1;

    logic [ACCWIDTH:0]   full;
    logic [ACCWIDTH-1:0] raw;

    assign full = {1'b0, a} + {1'b0, b};
    assign raw  = full[ACCWIDTH-1:0];

    // A signed overflow can only go toward the sign both operands share,
    // so the sign of `a` picks which limit to clamp to.
    always_comb begin
        if (SIGNED != 0)
            ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
        else
            ovf = full[ACCWIDTH];
        sum = raw;
        if ((SATURATE != 0) && ovf)
            sum = ((SIGNED != 0) && a[MSB]) ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/add_accum.sv
// Streaming packet accumulator: sums the operands of each valid/ready packet
// and presents sum, beat count and sticky overflow on a valid/ready output.
module add_accum
    import add_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 16,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACCWIDTH-1:0]  out_sum,
    output logic [COUNT_W-1:0]   out_count,
    output logic                 out_ovf
);

    state_t               state;
    logic [ACCWIDTH-1:0]  acc;
    logic [ACCWIDTH-1:0]  ext_data;
    logic [ACCWIDTH-1:0]  step_sum;
    logic [ACCWIDTH-1:0]  nxt_acc;
    logic [COUNT_W-1:0]   cnt;
    logic [COUNT_W-1:0]   nxt_cnt;
    logic                 ovf_acc;
    logic                 step_ovf;
    logic                 nxt_ovf;
    logic                 accept;

    assign in_ready = Rst && (state != HOLD);
    assign accept   = in_valid && in_ready;

    if (SIGNED != 0) begin : g_sext
        assign ext_data = ACCWIDTH'($signed(in_data));
    end else begin : g_zext
        assign ext_data = ACCWIDTH'(in_data);
    end

    sat_add #(
        .ACCWIDTH (ACCWIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a   (acc),
        .b   (ext_data),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    // The first beat of a packet restarts the running values instead of adding.
    always_comb begin
        if (state == IDLE) begin
            nxt_acc = ext_data;
            nxt_cnt = COUNT_W'(1);
            nxt_ovf = 1'b0;
        end else begin
            nxt_acc = step_sum;
            nxt_cnt = (cnt == '1) ? cnt : cnt + COUNT_W'(1);
            nxt_ovf = ovf_acc | step_ovf;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc     <= nxt_acc;
                        cnt     <= nxt_cnt;
                        ovf_acc <= nxt_ovf;
                        if (in_last) begin
                            out_sum   <= nxt_acc;
                            out_count <= nxt_cnt;
                            out_ovf   <= nxt_ovf;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_accum.sv
// Drives five add_accum configurations in lockstep and compares every result
// against an arithmetic reference computed from the packet operands.
module tb_add_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir  [5];
    logic        ov  [5];
    logic [15:0] cnt [5];
    logic        ovf [5];
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [7:0]  sum2;
    logic [7:0]  sum3;
    logic [11:0] sum4;

    int total = 0;
    int bad   = 0;

    // Configuration table mirrors the instance parameters below.
    int cfg_aw [5] = '{16, 8, 8, 8, 12};
    bit cfg_sg [5] = '{0, 0, 0, 1, 1};
    bit cfg_st [5] = '{0, 0, 1, 1, 0};

    always #5 clk = ~clk;

    add_accum #(.DATAWIDTH(8), .ACCWIDTH(16), .SIGNED(0), .SATURATE(0)) dut0 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(sum0),
        .out_count(cnt[0]), .out_ovf(ovf[0]));
    add_accum #(.DATAWIDTH(8), .ACCWIDTH(8), .SIGNED(0), .SATURATE(0)) dut1 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(sum1),
        .out_count(cnt[1]), .out_ovf(ovf[1]));
    add_accum #(.DATAWIDTH(8), .ACCWIDTH(8), .SIGNED(0), .SATURATE(1)) dut2 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(sum2),
        .out_count(cnt[2]), .out_ovf(ovf[2]));
    add_accum #(.DATAWIDTH(8), .ACCWIDTH(8), .SIGNED(1), .SATURATE(1)) dut3 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready), .out_sum(sum3),
        .out_count(cnt[3]), .out_ovf(ovf[3]));
    add_accum #(.DATAWIDTH(8), .ACCWIDTH(12), .SIGNED(1), .SATURATE(0)) dut4 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .in_data(in_data),
        .in_last(in_last), .out_valid(ov[4]), .out_ready(out_ready), .out_sum(sum4),
        .out_count(cnt[4]), .out_ovf(ovf[4]));

    function automatic longint obsSum(input int k);
        case (k)
            0:       return longint'(sum0);
            1:       return longint'(sum1);
            2:       return longint'(sum2);
            3:       return longint'(sum3);
            default: return longint'(sum4);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Exact integer sum per beat, then range check, clamp or modular wrap.
    task automatic model(input int k, input int data[$],
                         output longint s, output longint c, output longint o);
        longint one, span, hi, lo, acc, t, v;
        one  = 1;
        span = one << cfg_aw[k];
        hi   = cfg_sg[k] ? (one << (cfg_aw[k] - 1)) - 1 : span - 1;
        lo   = cfg_sg[k] ? -(one << (cfg_aw[k] - 1)) : 0;
        acc  = 0;
        c    = 0;
        o    = 0;
        for (int i = 0; i < data.size(); i++) begin
            v = longint'(data[i]);
            if (cfg_sg[k] && v > 127)
                v = v - 256;
            if (i == 0) begin
                acc = v;
            end else begin
                t = acc + v;
                if (t > hi || t < lo) begin
                    o = 1;
                    if (cfg_st[k]) begin
                        t = (t > hi) ? hi : lo;
                    end else begin
                        t = ((t % span) + span) % span;
                        if (t > hi)
                            t = t - span;
                    end
                end
                acc = t;
            end
            if (c < 65535)
                c = c + 1;
        end
        s = acc & (span - 1);
    endtask

    task automatic checkAll(input string tag, input longint es[5], input longint ec[5],
                            input longint eo[5], input bit exp_valid, input bit exp_ready);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("%s_valid%0d", tag, k), longint'(ov[k]), longint'(exp_valid));
            checkOutput($sformatf("%s_ready%0d", tag, k), longint'(ir[k]), longint'(exp_ready));
            checkOutput($sformatf("%s_sum%0d", tag, k), obsSum(k), es[k]);
            checkOutput($sformatf("%s_count%0d", tag, k), longint'(cnt[k]), ec[k]);
            checkOutput($sformatf("%s_ovf%0d", tag, k), longint'(ovf[k]), eo[k]);
        end
    endtask

    // Presents one beat from a negedge and holds it until the accepting posedge.
    task automatic sendBeat(input int d, input bit last);
        int guard;
        in_valid = 1'b1;
        in_data  = d[7:0];
        in_last  = last;
        guard = 0;
        while (!ir[0] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20)
            checkOutput("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // bubbles: 0 none, 1 one idle cycle (with in_last high) between beats, 2 random.
    task automatic applyStimulus(input int data[$], input int bubbles, input int hold_cycles);
        longint es[5], ec[5], eo[5];
        for (int k = 0; k < 5; k++)
            model(k, data, es[k], ec[k], eo[k]);
        for (int i = 0; i < data.size(); i++) begin
            @(negedge clk);
            if (i > 0 && (bubbles == 1 || (bubbles == 2 && $urandom_range(0, 1) == 1))) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'b1;
                @(negedge clk);
            end
            sendBeat(data[i], i == data.size() - 1);
        end
        @(negedge clk);
        checkAll("result", es, ec, eo, 1'b1, 1'b0);
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            checkAll("hold", es, ec, eo, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkAll("release", es, ec, eo, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int q[$];
        int len;
        longint zs[5], zc[5], zo[5];
        for (int k = 0; k < 5; k++) begin
            zs[k] = 0;
            zc[k] = 0;
            zo[k] = 0;
        end

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkAll("reset", zs, zc, zo, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", longint'(ir[0]), 1);

        q = {10, 20, 30};
        applyStimulus(q, 0, 0);
        checkOutput("plan_sum_60", longint'(sum0), 60);

        q = {200, 100};
        applyStimulus(q, 0, 0);
        checkOutput("plan_wrap_44", longint'(sum1), 44);
        checkOutput("plan_sat_255", longint'(sum2), 255);

        q = {156, 156};
        applyStimulus(q, 0, 0);
        checkOutput("plan_smin", longint'(sum3), 128);

        q = {127, 1, 255};
        applyStimulus(q, 0, 0);
        checkOutput("plan_sclamp_126", longint'(sum3), 126);
        checkOutput("plan_sclamp_ovf", longint'(ovf[3]), 1);

        q = {42, 9};
        applyStimulus(q, 0, 5);
        q = {7};
        applyStimulus(q, 0, 0);
        checkOutput("plan_single_7", longint'(sum0), 7);

        @(negedge clk);
        sendBeat(5, 1'b0);
        @(negedge clk);
        sendBeat(6, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("midreset", zs, zc, zo, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q = {3};
        applyStimulus(q, 0, 0);
        checkOutput("plan_after_reset_3", longint'(sum0), 3);

        q = {1, 2, 3};
        applyStimulus(q, 1, 0);
        checkOutput("plan_bubble_6", longint'(sum0), 6);
        checkOutput("plan_bubble_cnt", longint'(cnt[0]), 3);

        for (int p = 0; p < 30; p++) begin
            q.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                q.push_back(int'($urandom_range(0, 255)));
            applyStimulus(q, 2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_accum.md
# add_accum

Streaming accumulator, the parametrised successor to the datapath library's combinational adder. It sums a packet of operands delivered over a valid/ready input stream and returns one result per packet, with beat count and overflow flag, over a valid/ready output stream. It supports signed or unsigned operands and wrap-around or saturating arithmetic. Intended for HLS-generated datapaths that need reductions of variable length without an external control FSM.

## Interface
- DATAWIDTH, 8, operand width in bits.
- ACCWIDTH, 16, accumulator/result width in bits; must be ≥ DATAWIDTH.
- SIGNED, 0, 1 = two's-complement operands/result; 0 = unsigned.
- SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^ACCWIDTH.

- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATAWIDTH  operand.
- in_last  in  1  marks final beat of packet.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACCWIDTH  packet sum.
- out_count  out  16  beats in packet, saturating at 16'hFFFF.
- out_ovf  out  1  sticky: an overflow occurred anywhere in the packet.

## Operation
- States: IDLE, ACCUM, HOLD.
- in_ready = (Rst high) and (state ≠ HOLD). A beat is accepted when in_valid && in_ready.
- Operand extension: sign-extend when SIGNED=1, otherwise zero-extend, to ACCWIDTH.
- IDLE, beat accepted:
  - acc ← ext(in_data), cnt ← 1, ovf ← 0.
  - If in_last: go to HOLD. Otherwise go to ACCUM.
- ACCUM, beat accepted:
  - acc ← acc + ext(in_data); cnt ← cnt + 1 (saturating); ovf ← ovf | step_ovf.
  - If in_last: go to HOLD.
- Entering HOLD: out_sum, out_count, out_ovf are loaded with the final values and out_valid goes to 1.
- HOLD: outputs stay stable until out_ready is sampled high. Next state is IDLE with out_valid = 0. out_sum, out_count and out_ovf keep their values until the next result.
- step_ovf definition:
  - Unsigned: carry out of the ACCWIDTH-bit add.
  - Signed: both operands have the same sign and the sum's sign differs.
- Result on overflow:
  - SATURATE=1: result clamps to max (unsigned 2^ACCWIDTH−1; signed 2^(ACCWIDTH−1)−1) or to signed min −2^(ACCWIDTH−1).
  - SATURATE=0: result wraps.
- A clamped accumulator keeps accumulating from the clamped value.
- in_last with in_valid low is ignored.
- A reset mid-packet discards the partial sum. No output is produced for that packet.

## Timing
- Reset values: state IDLE, out_valid 0, out_sum 0, out_count 0, out_ovf 0. in_ready is 0 while Rst is low and 1 in the first cycle after release.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Throughput: an N-beat packet occupies N accept cycles plus at least one HOLD cycle. The next packet's first beat can be accepted the cycle after the out_valid && out_ready handshake.
- There is no combinational path from in_* to out_*. in_ready depends only on state and Rst.
- Single-beat packet (in_last on the first beat) is legal: count 1, sum ext(in_data).

## Structure
- Package add_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - the COUNT_W = 16 constant;
  - the max/min constant functions for a given width and signedness.
- Sub-module sat_add: combinational ACCWIDTH adder.
  - Parameters: ACCWIDTH, SIGNED, SATURATE.
  - Ports: a, b in; sum, ovf out.
  - Instantiated once inside add_accum.
- add_accum holds only the FSM, the counter and the registers.

## Test plan
- Unsigned wrap, DATAWIDTH=8, ACCWIDTH=16: beats 10, 20, 30 (last) → out_sum 60, out_count 3, out_ovf 0, one cycle after the last beat.
- Unsigned wrap, ACCWIDTH=8: beats 200, 100 (last) → out_sum 44, out_ovf 1. Same stimulus with SATURATE=1 → out_sum 255, out_ovf 1.
- Signed saturate, DATAWIDTH=ACCWIDTH=8: beats −100, −100 (last) → out_sum −128, out_ovf 1. Beats 127, 1, −1 (last) → out_sum 126, out_ovf 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → in_ready stays 0, outputs stay stable. Raise out_ready → out_valid drops the next cycle, then a new single-beat packet of 7 → out_sum 7, out_count 1.
- Reset mid-packet: beats 5, 6, then assert Rst for 1 cycle → all outputs 0. A following packet 3 (last) → out_sum 3, out_count 1.
- Bubbles: in_valid toggles 1,0,1,0,1 with data 1, 2, 3 (last on third) → out_sum 6, out_count 3. in_last asserted with in_valid low is ignored.
